event_capture: RTL
==================

# event_capture

Hardware event front-end that sits directly upstream of the generated register pool. It synchronises asynchronous event lines, detects rising edges and keeps sticky pending bits that the pool exposes as a status field through `hwif_in.*.next`. It coalesces unmasked events into a single level interrupt and maintains the free-running 64-bit timestamp that feeds the TIMESTAMP_HIGHER/LOWER status registers. Mask and clear inputs come from `hwif_out` fields of the same pool.

## Interface
- `NUM_EVENTS`, 8: number of event lines; legal range 1..32.
- `SYNC_STAGES`, 2: synchroniser flops per event line; minimum 2.
- `COALESCE_W`, 8: width of the coalescing threshold and counter.

- `ACLK` in 1: the single clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `EVENT_IN` in NUM_EVENTS: asynchronous level event sources.
- `MASK` in NUM_EVENTS: 1 masks the event from the IRQ path; pending capture is unaffected.
- `CLEAR` in NUM_EVENTS: one-cycle W1C strobes from the pool.
- `COALESCE_THR` in COALESCE_W: number of event cycles needed to raise IRQ; 0 is treated as 1.
- `PENDING` out NUM_EVENTS: sticky pending bits.
- `IRQ` out 1: level interrupt, registered.
- `EVENT_COUNT` out 32: total detected edges, saturating.
- `TS_VALUE` out 64: free-running cycle timestamp.
- `TS_CAPTURE` out 64: timestamp of the last IRQ assertion.

## Operation
- Reset values: every synchroniser flop, the edge-history flop, `PENDING`, `IRQ`, `EVENT_COUNT`, `TS_VALUE`, `TS_CAPTURE` and the coalescing counter are 0. The FSM resets to IDLE.
- Edge detection: `edge[i] = sync[i] & ~prev[i]`.
  - A line held high across reset release produces one edge.
- Pending: `PENDING[i]` sets on `edge[i]` and clears on `CLEAR[i]`.
  - If both occur in the same cycle, the set wins, so no event is lost.
- Definitions:
  - `new_evt = |(edge & ~MASK)`.
  - `live = |(PENDING & ~MASK)`, using registered values.
  - `thr = max(COALESCE_THR, 1)`.
- FSM states: IDLE, ACCUM, ASSERTED.
  - IDLE, on `new_evt`: go to ASSERTED if `thr == 1`; otherwise go to ACCUM with `cnt = 1`.
  - ACCUM, on `new_evt`: `cnt + 1`; go to ASSERTED when `cnt + 1 >= thr`. Clears do not leave ACCUM; the accumulated count is kept.
  - ASSERTED, when `live == 0`: go to IDLE with `cnt = 0`. Further events in ASSERTED are ignored by the counter.
  - `new_evt` counts once per cycle, regardless of how many bits have edges.
- `IRQ` is registered and equals `state == ASSERTED`.
- `MASK` changes:
  - Masking every live bit while ASSERTED drops `IRQ` one cycle later.
  - Unmasking an already pending bit is not a new event.
- `EVENT_COUNT` increments by popcount(`edge`) for masked and unmasked lines alike, and saturates at 0xFFFF_FFFF.
- `TS_VALUE` increments by 1 every cycle and wraps from 2^64-1 to 0.
- `COALESCE_THR` is sampled every cycle. Lowering it below `cnt` while in ACCUM takes effect at the next `new_evt`.

## Timing
- `EVENT_IN` rising is first sampled at clock edge k. `PENDING` rises at edge k+SYNC_STAGES.
- With `thr == 1`, `IRQ` rises on the same edge as `PENDING`.
- `CLEAR` at edge c: `PENDING` falls at c+1. If that leaves `live == 0`, `IRQ` falls at c+2.
- `EVENT_IN` pulses shorter than one ACLK period may be missed. Lines must be held at least 2 cycles.
- Asserting `ARESETN` low mid-operation clears all state immediately. No event is remembered across reset.

## Configuration
- `EVENT_TIMESTAMP_EN` defined: `TS_CAPTURE` loads the `TS_VALUE` of the cycle in which the FSM decides to enter ASSERTED. It is visible on the edge where `IRQ` rises and is held until the next entry into ASSERTED.
- `EVENT_TIMESTAMP_EN` undefined: no capture register is built and `TS_CAPTURE` is tied to 0. `TS_VALUE` is always present.

## Structure
- Package `event_capture_pkg` holds:
  - the FSM state enum `evt_state_t` (IDLE, ACCUM, ASSERTED);
  - `EVT_MAX_EVENTS = 32`;
  - `EVT_COUNT_W = 32`;
  - `EVT_TS_W = 64`.
- Sub-module `event_sync`: a per-line synchroniser chain plus edge-history flop, outputting `edge`. It is instantiated NUM_EVENTS times with a generate loop.

## Test plan
- Basic capture: `COALESCE_THR = 0`, `MASK = 0`, pulse `EVENT_IN[3]` high for 4 cycles → `PENDING = 0x08` and `IRQ = 1` on the same edge, `EVENT_COUNT = 1`. Then `CLEAR = 0x08` → `PENDING = 0`, and `IRQ` falls one cycle later.
- Coalescing: `COALESCE_THR = 3`, three separate pulses on bit 0 → `IRQ` stays 0 after the first two and rises with the third.
- Same-cycle pulses: two pulses on bits 1 and 2 in the same cycle count as one event cycle, and `EVENT_COUNT` goes up by 2.
- Mask path: `MASK = 0xFF`, pulse bit 5 → `PENDING = 0x20`, `IRQ` stays 0. Unmasking does not raise `IRQ`.
- Set/clear collision: `CLEAR[2]` coincides with a new `edge[2]` → `PENDING[2]` stays 1.
  - Same test: with the FSM ASSERTED on bit 2, masking bit 2 drops `IRQ`.
- Reset and timestamp:
  - `ARESETN` low mid-ACCUM → all outputs 0 immediately.
  - `EVENT_IN[0]` held high through reset release → one edge, and `PENDING[0]` sets 2 cycles after release.
  - With `EVENT_TIMESTAMP_EN`, `TS_CAPTURE` equals `TS_VALUE - 1` on the `IRQ` rising edge.

Source files
------------

// File: rtl/event_capture_pkg.sv
// Shared types and constants for the event capture front-end.
// Optional feature macro used by the top level: EVENT_TIMESTAMP_EN.
package event_capture_pkg;

    // Interrupt coalescing FSM states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        ASSERTED = 2'd2
    } evt_state_t;

    localparam int EVT_MAX_EVENTS = 32;
    localparam int EVT_COUNT_W    = 32;
    localparam int EVT_TS_W       = 64;

    // Number of set bits in a full-width event vector (0..32).
    function automatic logic [5:0] evt_popcount(input logic [EVT_MAX_EVENTS-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < EVT_MAX_EVENTS; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/event_capture_sync.sv
// Per-line synchroniser chain plus edge-history flop; emits a one-cycle
// rising-edge pulse for one asynchronous event line.
module event_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw line through the synchroniser and remember the last synced level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // The history flop resets to 0, so a line held high across reset yields one edge.
    assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/event_capture.sv
// Event capture front-end: synchronised edge detection, sticky pending bits,
// coalesced level interrupt, saturating edge counter and 64-bit timestamp.
// Define EVENT_TIMESTAMP_EN to build the TS_CAPTURE register; otherwise
// TS_CAPTURE is tied to 0.
// NUM_EVENTS must be 1..32, SYNC_STAGES at least 2.
module event_capture
    import event_capture_pkg::*;
#(
    parameter int NUM_EVENTS  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int COALESCE_W  = 8
) (
    input  logic                   ACLK,
    input  logic                   ARESETN,
    input  logic [NUM_EVENTS-1:0]  EVENT_IN,
    input  logic [NUM_EVENTS-1:0]  MASK,
    input  logic [NUM_EVENTS-1:0]  CLEAR,
    input  logic [COALESCE_W-1:0]  COALESCE_THR,
    output logic [NUM_EVENTS-1:0]  PENDING,
    output logic                   IRQ,
    output logic [EVT_COUNT_W-1:0] EVENT_COUNT,
    output logic [EVT_TS_W-1:0]    TS_VALUE,
    output logic [EVT_TS_W-1:0]    TS_CAPTURE,
    output logic [1:0]             o_dbg_state
);

    logic [NUM_EVENTS-1:0]  w_edge;
    logic [NUM_EVENTS-1:0]  r_pending;
    logic                   r_irq;
    logic [EVT_COUNT_W-1:0] r_count;
    logic [EVT_TS_W-1:0]    r_ts;
    logic [COALESCE_W-1:0]  r_cnt;
    evt_state_t             r_state;

    logic                   w_new_evt;
    logic                   w_live;
    logic [COALESCE_W-1:0]  w_thr;
    logic [COALESCE_W-1:0]  w_cnt_next;
    logic                   w_enter;
    logic [5:0]             w_pop;
    logic [EVT_COUNT_W:0]   w_count_sum;

    // One synchroniser/edge detector per event line.
    for (genvar g = 0; g < NUM_EVENTS; g++) begin : g_sync
        event_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk   (ACLK),
            .i_rst_n (ARESETN),
            .i_async (EVENT_IN[g]),
            .o_edge  (w_edge[g])
        );
    end

    // Any unmasked edge is one event cycle, however many lines fired.
    assign w_new_evt = |(w_edge & ~MASK);
    // Live uses the registered pending bits against the current mask.
    assign w_live    = |(r_pending & ~MASK);
    // A zero threshold behaves like 1.
    assign w_thr     = (COALESCE_THR == '0) ? COALESCE_W'(1) : COALESCE_THR;
    // Count this event would reach: 1 from IDLE, cnt+1 from ACCUM. cnt stays
    // below the largest threshold ever seen, so cnt+1 cannot wrap.
    assign w_cnt_next = (r_state == IDLE) ? COALESCE_W'(1) : r_cnt + COALESCE_W'(1);
    // Decision to enter ASSERTED this cycle; also drives the timestamp capture.
    assign w_enter   = w_new_evt && (r_state != ASSERTED) && (w_cnt_next >= w_thr);

    assign w_pop       = evt_popcount(EVT_MAX_EVENTS'(w_edge));
    assign w_count_sum = {1'b0, r_count} + (EVT_COUNT_W+1)'(w_pop);

    // Sticky pending bits: a new edge wins over a same-cycle clear.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~CLEAR) | w_edge;
        end
    end

    // Saturating total of detected edges, masked or not.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_count <= '0;
        end else if (w_count_sum[EVT_COUNT_W]) begin
            r_count <= '1;
        end else begin
            r_count <= w_count_sum[EVT_COUNT_W-1:0];
        end
    end

    // Free-running cycle timestamp, wraps naturally.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + EVT_TS_W'(1);
        end
    end

    // Coalescing FSM with registered IRQ that mirrors the ASSERTED state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_irq   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_new_evt) begin
                        r_cnt <= w_cnt_next;
                        if (w_enter) begin
                            r_state <= ASSERTED;
                            r_irq   <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                ASSERTED: begin
                    // New events here are ignored; only losing every live bit leaves.
                    if (!w_live) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_irq   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_irq   <= 1'b0;
                end
            endcase
        end
    end

`ifdef EVENT_TIMESTAMP_EN
    logic [EVT_TS_W-1:0] r_ts_cap;

    // Latch the timestamp of the deciding cycle; visible when IRQ rises.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_ts_cap <= '0;
        end else if (w_enter) begin
            r_ts_cap <= r_ts;
        end
    end

    assign TS_CAPTURE = r_ts_cap;
`else
    assign TS_CAPTURE = '0;
`endif

    assign PENDING     = r_pending;
    assign IRQ         = r_irq;
    assign EVENT_COUNT = r_count;
    assign TS_VALUE    = r_ts;
    assign o_dbg_state = r_state;

endmodule
